// File: rtl/four_bit_serial_tx_if.sv
// Purpose : parallel word handshake into the serial transmitter (word + valid/ready).
// Latency : n/a (signal bundle only).
// Backpressure: producer holds d_valid/d_in until it sees d_ready high at a clock edge.
//
// Signals:
//   d_in    - parallel word to transmit (producer -> transmitter)
//   d_valid - d_in holds a word to send (producer -> transmitter)
//   d_ready - transmitter can accept a word this cycle (transmitter -> producer)
interface four_bit_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] d_in;
  logic              d_valid;
  logic              d_ready;

  // Producer side: drives the word and valid, watches ready.
  modport master (
    output d_in,
    output d_valid,
    input  d_ready
  );

  // Transmitter side: samples the word and valid, drives ready.
  modport slave (
    input  d_in,
    input  d_valid,
    output d_ready
  );
endinterface

// File: rtl/four_bit_serial_tx.sv
// Purpose : parallel-in serial-out transmitter; frame = start(0), DATA_W bits LSB first, stop(1).
// Latency : line goes low 1 cycle after the accepting edge; frame lasts (DATA_W+2)*CLKS_PER_BIT cycles.
// Backpressure: d_ready only in IDLE (and never during rst); words offered while busy are held off.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst    - synchronous active-high reset
//   in_if  - slave side of the word handshake (d_in, d_valid, d_ready)
//   tx_out - serial line, registered, idles high
//   busy   - registered, high for every cycle of a frame (START, DATA, STOP)
module four_bit_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  four_bit_serial_tx_if.slave  in_if,
  output logic                 tx_out,
  output logic                 busy
);

  // Counters are sized to the largest value they hold so neither can wrap
  // inside a bit period or a frame; a 1-bit floor keeps the degenerate
  // CLKS_PER_BIT=1 / DATA_W=1 builds legal.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;
  logic                tx_q,    tx_d;
  logic                busy_q,  busy_d;

  logic                d_ready_w;
  logic                accept;
  logic                bit_end;

  // Ready is the only combinational output; gating with rst guarantees a
  // word offered together with reset is never considered taken.
  assign d_ready_w     = (state_q == IDLE) && !rst;
  assign in_if.d_ready = d_ready_w;

  assign accept  = in_if.d_valid && d_ready_w;
  assign bit_end = (div_q == DIV_LAST);

  assign tx_out = tx_q;
  assign busy   = busy_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and registered-output logic. tx_d/busy_d are the line level
  // and busy flag for the *next* cycle, so each transition also sets the
  // level the new state drives in its first cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          // Capture the word now; later changes on d_in cannot reach the line.
          shift_d = in_if.d_in;
          div_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            // Bit counter stops at its last value rather than wrapping.
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shift_d[0];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_four_bit_serial_tx.sv
// Purpose : self-checking bench for four_bit_serial_tx (CLKS_PER_BIT=4 and =1 instances).
// Latency : inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: bench offers words and observes d_ready/busy directly.
module tb_four_bit_serial_tx;

  logic clk;
  logic rst;
  logic tx_a, busy_a;
  logic tx_b, busy_b;

  int checks;
  int errors;

  four_bit_serial_tx_if #(.DATA_W(4)) bus_a ();
  four_bit_serial_tx_if #(.DATA_W(4)) bus_b ();

  four_bit_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .in_if  (bus_a.slave),
    .tx_out (tx_a),
    .busy   (busy_a)
  );

  four_bit_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .in_if  (bus_b.slave),
    .tx_out (tx_b),
    .busy   (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_a cyc %0d: tx=%b busy=%b rdy=%b, expected tx=1 busy=0 rdy=0",
                 c, tx_a, busy_a, bus_a.d_ready);
      end
      checks++;
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || bus_b.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_b cyc %0d: tx=%b busy=%b rdy=%b, expected tx=1 busy=0 rdy=0",
                 c, tx_b, busy_b, bus_b.d_ready);
      end
    end
    rst = 1'b0;
    bus_a.d_valid = 1'b0;
    bus_b.d_valid = 1'b0;
    #1;
    checks++;
    if (bus_a.d_ready !== 1'b1 || bus_b.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: rdy_a=%b rdy_b=%b, expected 1 1",
               bus_a.d_ready, bus_b.d_ready);
    end
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || tx_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_frame: tx_a=%b busy_a=%b tx_b=%b busy_b=%b, expected 1 0 1 0",
               tx_a, busy_a, tx_b, busy_b);
    end
  endtask

  task automatic test_single();
    logic [5:0] exp;
    exp = 6'b110100;  // groups: start 0, data 0,1,0,1, stop 1
    bus_a.d_in    = 4'd10;
    bus_a.d_valid = 1'b1;
    checks++;
    if (tx_a !== 1'b1 || bus_a.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_pre: tx=%b rdy=%b, expected 1 1", tx_a, bus_a.d_ready);
    end
    tick();
    bus_a.d_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_a !== exp[c/4] || busy_a !== 1'b1 || bus_a.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_frame cyc %0d: tx=%b busy=%b rdy=%b, expected tx=%b busy=1 rdy=0",
                 c, tx_a, busy_a, bus_a.d_ready, exp[c/4]);
      end
    end
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_end: tx=%b busy=%b rdy=%b, expected 1 0 1", tx_a, busy_a, bus_a.d_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp1;
    logic [5:0] exp2;
    exp1 = 6'b111110;  // word 15
    exp2 = 6'b100000;  // word 0
    bus_a.d_in    = 4'd15;
    bus_a.d_valid = 1'b1;
    tick();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_a !== exp1[c/4] || busy_a !== 1'b1 || bus_a.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame1 cyc %0d: tx=%b busy=%b rdy=%b, expected tx=%b busy=1 rdy=0",
                 c, tx_a, busy_a, bus_a.d_ready, exp1[c/4]);
      end
      if (c == 0) bus_a.d_in = 4'd0;
    end
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: tx=%b busy=%b rdy=%b, expected 1 0 1", tx_a, busy_a, bus_a.d_ready);
    end
    tick();
    bus_a.d_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_a !== exp2[c/4] || busy_a !== 1'b1 || bus_a.d_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame2 cyc %0d: tx=%b busy=%b rdy=%b, expected tx=%b busy=1 rdy=0",
                 c, tx_a, busy_a, bus_a.d_ready, exp2[c/4]);
      end
    end
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: tx=%b busy=%b, expected 1 0", tx_a, busy_a);
    end
  endtask

  task automatic test_ignore_busy();
    logic [5:0] exp;
    int extra;
    exp = 6'b101010;  // word 5: data 1,0,1,0
    bus_a.d_in    = 4'd5;
    bus_a.d_valid = 1'b1;
    tick();
    bus_a.d_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_a !== exp[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL busy_ignore cyc %0d: tx=%b busy=%b, expected tx=%b busy=1",
                 c, tx_a, busy_a, exp[c/4]);
      end
      // Pulse valid with word 3 mid-frame, then keep scrambling d_in.
      bus_a.d_valid = (c >= 6 && c < 10);
      if (c >= 6 && c < 14) bus_a.d_in = 4'(3 + (c - 6) * 5);
    end
    bus_a.d_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (busy_a !== 1'b0 || tx_a !== 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_no_extra_frame: %0d busy/low cycles after frame, expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp1;
    logic [5:0] exp2;
    exp1 = 6'b110100;  // word 10
    exp2 = 6'b111110;  // word 15
    bus_a.d_in    = 4'd10;
    bus_a.d_valid = 1'b1;
    tick();
    bus_a.d_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_a !== exp1[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_pre cyc %0d: tx=%b busy=%b, expected tx=%b busy=1",
                 c, tx_a, busy_a, exp1[c/4]);
      end
    end
    rst = 1'b1;  // lands inside the second data bit
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.d_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: tx=%b busy=%b rdy=%b, expected 1 0 0", tx_a, busy_a, bus_a.d_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_a.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: rdy=%b, expected 1", bus_a.d_ready);
    end
    bus_a.d_in    = 4'd15;
    bus_a.d_valid = 1'b1;
    tick();
    bus_a.d_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_a !== exp2[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_clean cyc %0d: tx=%b busy=%b, expected tx=%b busy=1",
                 c, tx_a, busy_a, exp2[c/4]);
      end
    end
    tick();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_end: tx=%b busy=%b, expected 1 0", tx_a, busy_a);
    end
  endtask

  task automatic test_cpb1();
    logic [5:0] exp;
    exp = 6'b100000;  // word 0, one cycle per bit
    bus_b.d_in    = 4'd0;
    bus_b.d_valid = 1'b1;
    checks++;
    if (bus_b.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL cpb1_ready: rdy=%b, expected 1", bus_b.d_ready);
    end
    tick();
    bus_b.d_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      checks++;
      if (tx_b !== exp[c] || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL cpb1_frame cyc %0d: tx=%b busy=%b, expected tx=%b busy=1",
                 c, tx_b, busy_b, exp[c]);
      end
    end
    tick();
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || bus_b.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL cpb1_end: tx=%b busy=%b rdy=%b, expected 1 0 1", tx_b, busy_b, bus_b.d_ready);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus_a.d_in    = 4'd5;
    bus_a.d_valid = 1'b1;
    bus_b.d_in    = 4'd5;
    bus_b.d_valid = 1'b1;

    test_reset();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_ignore_busy();
    test_reset_mid();
    tick();
    test_cpb1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_serial_tx.md
Name: four_bit_serial_tx

Overview:
- Parallel-in, serial-out transmitter for 4-bit words.
- Accepts a word on a valid/ready handshake and captures it into an internal shift register.
- Drives the word onto a single line as a frame: one start bit (0), DATA_W data bits LSB first, one stop bit (1).
- Sits on the output side of the 4-bit register path, feeding a matching serial receiver.

Parameters:
- DATA_W, 4, number of data bits per frame.
- CLKS_PER_BIT, 4, clk cycles each line bit is held; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  DATA_W  parallel word to transmit.
- d_valid  input  1  d_in holds a word to send.
- d_ready  output  1  transmitter can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (START, DATA or STOP state).

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge.
  - After the edge with rst=1: state=IDLE, tx_out=1, busy=0, d_ready=1, bit counter=0, clock-divide counter=0, shift register=0.
  - d_ready is 0 in any cycle where rst=1.
- States: IDLE, START, DATA, STOP. All outputs are registered, except d_ready = (state==IDLE) && !rst.
- IDLE:
  - tx_out=1, busy=0.
  - If d_valid && d_ready at an edge: load d_in into the shift register, clear the divide counter, move to START.
  - d_in is ignored in every other cycle.
- START:
  - tx_out=0 for CLKS_PER_BIT cycles, beginning the cycle after acceptance (1-cycle latency).
  - Then move to DATA with bit counter=0.
- DATA:
  - tx_out = shift register bit 0, held CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right by 1 and increment the bit counter.
  - After bit DATA_W-1 completes, move to STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - Then move to IDLE.
- Frame length is exactly (DATA_W+2)*CLKS_PER_BIT cycles; busy is high for exactly those cycles.
- Back-to-back words:
  - d_ready rises in the first IDLE cycle after STOP.
  - If d_valid is already high, the word is accepted at that edge.
  - Minimum idle-high gap between frames is therefore 1 cycle.
- d_valid asserted while busy: no acceptance, no state change; the in-flight frame is unaffected.
- d_in changes after acceptance: no effect on the frame in progress, because data is captured at acceptance.
- Reset mid-frame: the frame is aborted. The cycle after the rst edge shows the reset values (tx_out=1, busy=0). No partial data is retained.
- rst and d_valid high together: reset wins; the word is not accepted.
- CLKS_PER_BIT=1: each bit lasts one cycle; the frame is 6 cycles for DATA_W=4.
- Counter widths:
  - Divide counter is $clog2(CLKS_PER_BIT) bits, minimum 1.
  - Bit counter is $clog2(DATA_W) bits, minimum 1.
  - Neither counter may wrap within a bit or frame.

Test Plan:
- Reset: hold rst=1 for 2 cycles with d_valid=1, d_in=4'd5 -> tx_out=1, busy=0, d_ready=0 during reset, no frame starts; d_ready=1 in the first cycle after rst drops.
- Single word, CLKS_PER_BIT=4, d_in=4'd10 (1010), d_valid for one cycle:
  - Line sequence in 4-cycle groups: 0 (start), 0,1,0,1 (data, LSB first), 1 (stop).
  - busy high for 24 cycles; tx_out low begins exactly one cycle after the accepting edge.
- Back-to-back: hold d_valid=1, d_in=4'd15, then 4'd0 once the first word is accepted -> two frames separated by exactly one idle-high cycle; second frame data bits 0,0,0,0; d_ready high only in the single IDLE cycle between frames.
- Ignore while busy and data capture: send 4'd5; mid-frame, pulse d_valid with d_in=4'd3 and change d_in each cycle -> line still carries 1,0,1,0; 4'd3 is never transmitted; no extra frame follows.
- Reset mid-frame: send 4'd10; assert rst for 1 cycle during the second data bit -> next cycle tx_out=1, busy=0; a following 4'd15 request produces a clean full frame.
- Width and divider corners: CLKS_PER_BIT=1 and d_in=4'd0 -> 6-cycle frame: 0,0,0,0,0,1.
